// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result handshake bundle for the digit-serial add/sub unit.
interface addsub_serial_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             v;
  logic             zero;
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, ans, cout, v, zero);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, ans, cout, v, zero);
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: two's-complement add/sub, DIGIT bits per cycle through one carry chain.
// Define ADDSUB_SATURATE_EN to clamp overflowing results to the signed extreme.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic clk,
  input logic rst,
  addsub_serial_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, bx_r, raw, raw_nx, fin, ans_r;
  logic [DIGIT-1:0] s_nx;
  logic carry, c_nx, v_nx, last, cout_r, v_r, zero_r;
  assign last = cnt == CW'(NDIG - 1);
  assign {c_nx, s_nx} = {1'b0, a_r[cnt*DIGIT +: DIGIT]} + {1'b0, bx_r[cnt*DIGIT +: DIGIT]}
                      + {{DIGIT{1'b0}}, carry};
  always_comb begin
    raw_nx = raw;
    raw_nx[cnt*DIGIT +: DIGIT] = s_nx;
  end
  assign v_nx = (a_r[WIDTH-1] == bx_r[WIDTH-1]) & (raw_nx[WIDTH-1] != a_r[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
  assign fin = v_nx ? {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}} : raw_nx;
`else
  assign fin = raw_nx;
`endif
  always_comb begin
    nxt = st;
    nxt = (st == IDLE && bus.in_valid) ? RUN :
          (st == RUN && last)          ? DONE :
          (st == DONE && bus.out_ready) ? IDLE : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  // Flags and result only change on the final digit, so they stay stable outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      a_r <= '0;
      bx_r <= '0;
      raw <= '0;
      carry <= 1'b0;
      ans_r <= '0;
      cout_r <= 1'b0;
      v_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (st == IDLE && bus.in_valid) begin
      a_r <= bus.a;
      bx_r <= bus.b ^ {WIDTH{bus.sub}};
      carry <= bus.sub;
      cnt <= '0;
    end else if (st == RUN) begin
      raw <= raw_nx;
      carry <= c_nx;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        ans_r <= fin;
        cout_r <= c_nx;
        v_r <= v_nx;
        zero_r <= fin == '0;
      end
    end
  end
  assign bus.in_ready = st == IDLE;
  assign bus.out_valid = st == DONE;
  assign bus.ans = ans_r;
  assign bus.cout = cout_r;
  assign bus.v = v_r;
  assign bus.zero = zero_r;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: random and directed checks of addsub_serial against an arithmetic model.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  addsub_serial_if #(.WIDTH(32)) i8 ();
  addsub_serial_if #(.WIDTH(32)) i1 ();
  addsub_serial #(.WIDTH(32), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
  addsub_serial #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {ans, cout, v, zero} from plain signed/unsigned arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, r;
    logic [32:0] u;
    logic c, ov;
    logic [31:0] ans;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = s ? sa - sb : sa + sb;
    u = {1'b0, a} + {1'b0, b};
    c = s ? (a >= b) : u[32];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    ans = r[31:0];
`ifdef ADDSUB_SATURATE_EN
    if (ov) ans = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ans, c, ov, ans == 32'd0};
  endfunction

  task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i);
    logic [34:0] e;
    int n;
    e = model(a_i, b_i, s_i);
    check("in_ready_idle", i8.in_ready, 1);
    i8.a = a_i; i8.b = b_i; i8.sub = s_i; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    i8.a = $urandom; i8.b = $urandom; i8.sub = 1'($urandom);
    n = 0;
    while (!i8.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 4);
    check("ans", i8.ans, e[34:3]);
    check("cout", i8.cout, e[2]);
    check("v", i8.v, e[1]);
    check("zero", i8.zero, e[0]);
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0;
    check("idle_after", {i8.in_ready, i8.out_valid}, 2'b10);
  endtask

  initial begin
    logic [34:0] e;
    logic [31:0] held;
    int n;
    i8.in_valid = 0; i8.a = 0; i8.b = 0; i8.sub = 0; i8.out_ready = 0;
    i1.in_valid = 0; i1.a = 0; i1.b = 0; i1.sub = 0; i1.out_ready = 0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {i8.in_ready, i8.out_valid, i8.ans, i8.cout, i8.v, i8.zero}, {2'b10, 32'd0, 3'b000});
    rst = 1'b0;
    do_op(32'h0000_0021, 32'h0000_0022, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    do_op(32'h336F_B7E5, 32'h336F_B7E5, 1'b1);
    do_op(32'h0000_0000, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 25; i++) do_op($urandom, $urandom, 1'($urandom));
    // Backpressure: result must hold and new operands must be ignored.
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    i8.a = 32'h1234_5678; i8.b = 32'h0FED_CBA9; i8.sub = 1'b1; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    held = i8.ans;
    for (int i = 0; i < 5; i++) begin
      i8.in_valid = 1'($urandom); i8.a = $urandom; i8.b = $urandom; i8.sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_hold", {i8.out_valid, i8.in_ready, i8.ans, i8.cout, i8.v, i8.zero},
            {2'b10, e[34:3], e[2:0]});
    end
    check("bp_stable", i8.ans, held);
    i8.in_valid = 1'b1;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0;
    check("bp_release", {i8.in_ready, i8.out_valid}, 2'b10);
    i8.in_valid = 1'b0;
    do_op(32'h0000_0100, 32'h0000_0200, 1'b0);
    // Abort mid-RUN with asynchronous reset.
    i8.a = 32'h0F0F_0F0F; i8.b = 32'h0101_0101; i8.sub = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_abort", {i8.in_ready, i8.out_valid, i8.ans}, {2'b10, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_result", i8.out_valid, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    // One bit per cycle variant.
    e = model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    i1.a = 32'hFFFF_FFFF; i1.b = 32'h0000_0001; i1.sub = 1'b0; i1.in_valid = 1'b1;
    @(posedge clk); #1;
    i1.in_valid = 1'b0;
    n = 0;
    while (!i1.out_valid && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("d1_latency", n, 32);
    check("d1_flags", {i1.ans, i1.cout, i1.v, i1.zero}, {e[34:3], e[2:0]});
    check("d1_expect", {i1.ans, i1.cout, i1.v, i1.zero}, {32'd0, 3'b101});
    i1.out_ready = 1'b1;
    @(posedge clk); #1;
    i1.out_ready = 1'b0;
    check("d1_idle", i1.in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
